// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver: FSM states, parity modes and a parity helper.
// The BREAK state exists only when UART_TX_BREAK_EN is defined.
package uart_pkg;

    localparam int MAX_DATA_BITS = 9;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
`ifdef UART_TX_BREAK_EN
        ,
        BREAK
`endif
    } tx_state_t;

    // Narrower words are zero-extended by the caller, which leaves the XOR unchanged
    function automatic logic even_parity(input logic [MAX_DATA_BITS-1:0] d);
        return ^d;
    endfunction

    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Valid/ready word stream feeding the UART transmitter.
interface uart_tx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic                 s_valid;
    logic                 s_ready;
    logic [DATA_BITS-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/uart_bit_timer.sv
// Loadable baud down-counter; bit_done flags the last clk of a bit period.
module uart_bit_timer #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] load_val,
    output logic             bit_done
);

    logic [DIV_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - DIV_W'(1);
        end
    end

    assign bit_done = en && (count == '0);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, DATA_BITS data (LSB first), optional parity, 1 or 2 stop bits.
// Optional line-break generation is enabled by defining UART_TX_BREAK_EN.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int DIV_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [1:0]       parity_mode,
    input  logic             stop2,
`ifdef UART_TX_BREAK_EN
    input  logic             brk,
`endif
    uart_tx_frame_if.slave   s,
    output logic             tx,
    output logic             tx_busy
);

    localparam int IDX_W = $clog2(DATA_BITS + 1);

    tx_state_t            state;
    logic [DATA_BITS-1:0] shreg;
    logic [IDX_W-1:0]     bit_idx;
    logic [DIV_W-1:0]     cfg_div;
    logic                 par_en;
    logic                 par_bit;
    logic                 cfg_stop2;
    logic                 second_stop;
    logic                 ready_en;
    logic                 bit_done;
    logic                 last_stop_clk;
    logic                 idle_ready;
    logic                 xfer;
    logic                 timer_load;

    assign last_stop_clk = (state == STOP) && bit_done && (!cfg_stop2 || second_stop);

`ifdef UART_TX_BREAK_EN
    logic brk_release;
    logic brk_load;

    assign brk_load   = (state == BREAK) && !brk_release && !brk;
    assign idle_ready = (state == IDLE) && !brk;
    assign timer_load = xfer || bit_done || brk_load;
`else
    assign idle_ready = (state == IDLE);
    assign timer_load = xfer || bit_done;
`endif

    // Ready also in the final stop clk so a waiting word follows with no idle gap
    assign s.s_ready = ready_en && (idle_ready || last_stop_clk);
    assign xfer      = s.s_valid && s.s_ready;

    uart_bit_timer #(
        .DIV_W(DIV_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .en       (state != IDLE),
        .load_val (xfer ? baud_div : cfg_div),
        .bit_done (bit_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            tx          <= 1'b1;
            tx_busy     <= 1'b0;
            shreg       <= '0;
            bit_idx     <= '0;
            cfg_div     <= '0;
            par_en      <= 1'b0;
            par_bit     <= 1'b0;
            cfg_stop2   <= 1'b0;
            second_stop <= 1'b0;
            ready_en    <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_release <= 1'b0;
`endif
        end else begin
            ready_en <= 1'b1;
            // A transfer can only happen in IDLE or the last stop clk, so it overrides the state step
            if (xfer) begin
                state       <= START;
                tx          <= 1'b0;
                tx_busy     <= 1'b1;
                shreg       <= s.s_data;
                bit_idx     <= '0;
                cfg_div     <= baud_div;
                par_en      <= parity_enabled(parity_mode);
                par_bit     <= even_parity(MAX_DATA_BITS'(s.s_data)) ^ (parity_mode == PAR_ODD);
                cfg_stop2   <= stop2;
                second_stop <= 1'b0;
            end
`ifdef UART_TX_BREAK_EN
            else if ((state == IDLE) && brk) begin
                state       <= BREAK;
                tx          <= 1'b0;
                tx_busy     <= 1'b1;
                cfg_div     <= baud_div;
                brk_release <= 1'b0;
            end
`endif
            else begin
                case (state)
                    IDLE: begin
                        tx      <= 1'b1;
                        tx_busy <= 1'b0;
                    end
                    START: if (bit_done) begin
                        state   <= DATA;
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= IDX_W'(1);
                    end
                    DATA: if (bit_done) begin
                        if (bit_idx == IDX_W'(DATA_BITS)) begin
                            state       <= par_en ? PARITY : STOP;
                            tx          <= par_en ? par_bit : 1'b1;
                            second_stop <= 1'b0;
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end
                    PARITY: if (bit_done) begin
                        state       <= STOP;
                        tx          <= 1'b1;
                        second_stop <= 1'b0;
                    end
                    STOP: if (bit_done) begin
                        if (cfg_stop2 && !second_stop) begin
                            second_stop <= 1'b1;
                        end else begin
                            state   <= IDLE;
                            tx      <= 1'b1;
                            tx_busy <= 1'b0;
                        end
                    end
`ifdef UART_TX_BREAK_EN
                    // Hold the line low while brk is high, then one high bit time before IDLE
                    BREAK: begin
                        if (!brk_release) begin
                            if (!brk) begin
                                brk_release <= 1'b1;
                                tx          <= 1'b1;
                            end
                        end else if (bit_done) begin
                            state   <= IDLE;
                            tx_busy <= 1'b0;
                        end
                    end
`endif
                    default: begin
                        state   <= IDLE;
                        tx      <= 1'b1;
                        tx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: an 8-bit and a 5-bit instance checked cycle by cycle against a frame-level model.
// Define UART_TX_BREAK_EN to also exercise line-break generation.
module tb_uart_tx_frame;
    import uart_pkg::*;

    typedef struct {
        logic [8:0] d;
        int         div;
        logic [1:0] pm;
        logic       s2;
    } word_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] baud_div;
    logic [1:0]  parity_mode;
    logic        stop2;
    logic        valid;
    logic [8:0]  data;
    logic        sel;
    logic        tx8, busy8, tx5, busy5;
`ifdef UART_TX_BREAK_EN
    logic        brk;
`endif

    int    checks   = 0;
    int    failures = 0;
    logic  exp_tx[$];
    logic  exp_rdy[$];
    word_t words[$];

    always #5 clk = ~clk;

    uart_tx_frame_if #(.DATA_BITS(8)) if8 ();
    uart_tx_frame_if #(.DATA_BITS(5)) if5 ();

    assign if8.s_valid = valid && !sel;
    assign if8.s_data  = data[7:0];
    assign if5.s_valid = valid && sel;
    assign if5.s_data  = data[4:0];

    uart_tx_frame #(.DATA_BITS(8), .DIV_W(16)) u_dut8 (
        .clk         (clk),
        .reset       (reset),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .stop2       (stop2),
`ifdef UART_TX_BREAK_EN
        .brk         (brk),
`endif
        .s           (if8),
        .tx          (tx8),
        .tx_busy     (busy8)
    );

    uart_tx_frame #(.DATA_BITS(5), .DIV_W(16)) u_dut5 (
        .clk         (clk),
        .reset       (reset),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .stop2       (stop2),
`ifdef UART_TX_BREAK_EN
        .brk         (1'b0),
`endif
        .s           (if5),
        .tx          (tx5),
        .tx_busy     (busy5)
    );

    wire obs_tx   = sel ? tx5 : tx8;
    wire obs_busy = sel ? busy5 : busy8;
    wire obs_rdy  = sel ? if5.s_ready : if8.s_ready;

    task automatic check_output(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Expected line level for every clk of one frame; ready is expected only in its final clk
    function automatic void add_frame(input int nbits, input word_t w);
        logic bits[$];
        logic p = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < nbits; i++) begin
            bits.push_back(w.d[i]);
            p ^= w.d[i];
        end
        if (w.pm == 2'b01) bits.push_back(p);
        else if (w.pm == 2'b10) bits.push_back(!p);
        bits.push_back(1'b1);
        if (w.s2) bits.push_back(1'b1);
        foreach (bits[b]) begin
            for (int k = 0; k <= w.div; k++) begin
                exp_tx.push_back(bits[b]);
                exp_rdy.push_back(1'b0);
            end
        end
        exp_rdy[exp_rdy.size() - 1] = 1'b1;
    endfunction

    function automatic void add_word(input logic [8:0] d, input int div, input logic [1:0] pm, input logic s2);
        word_t w;
        w.d = d; w.div = div; w.pm = pm; w.s2 = s2;
        words.push_back(w);
    endfunction

    task automatic scramble_cfg();
        baud_div    = 16'($urandom);
        parity_mode = 2'($urandom);
        stop2       = 1'($urandom);
    endtask

    task automatic present_cfg(input word_t w);
        baud_div    = 16'(w.div);
        parity_mode = w.pm;
        stop2       = w.s2;
    endtask

    // Streams every queued word; valid stays high while words remain, config is garbage except at transfer edges
    task automatic apply_stimulus(input string name);
        int nxt;
        exp_tx.delete();
        exp_rdy.delete();
        foreach (words[i]) add_frame(sel ? 5 : 8, words[i]);
        @(negedge clk);
        valid = 1'b1;
        data  = words[0].d;
        present_cfg(words[0]);
        check_output({name, "_ready_idle"}, obs_rdy, 1'b1);
        nxt = 1;
        for (int c = 0; c < exp_tx.size(); c++) begin
            @(negedge clk);
            check_output($sformatf("%s_tx[%0d]", name, c), obs_tx, exp_tx[c]);
            check_output($sformatf("%s_busy[%0d]", name, c), obs_busy, 1'b1);
            check_output($sformatf("%s_ready[%0d]", name, c), obs_rdy, exp_rdy[c]);
            valid = (nxt < words.size());
            data  = valid ? words[nxt].d : 9'($urandom);
            if (exp_rdy[c] && (nxt < words.size())) begin
                present_cfg(words[nxt]);
                nxt++;
            end else begin
                scramble_cfg();
            end
        end
        @(negedge clk);
        check_output({name, "_tx_after"}, obs_tx, 1'b1);
        check_output({name, "_busy_after"}, obs_busy, 1'b0);
        check_output({name, "_ready_after"}, obs_rdy, 1'b1);
        words.delete();
    endtask

    initial begin
        reset = 1'b1;
        valid = 1'b0;
        data  = '0;
        sel   = 1'b0;
        scramble_cfg();
`ifdef UART_TX_BREAK_EN
        brk = 1'b0;
`endif
        #1;
        check_output("reset_tx8", tx8, 1'b1);
        check_output("reset_busy8", busy8, 1'b0);
        check_output("reset_tx5", tx5, 1'b1);
        check_output("reset_busy5", busy5, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_output("ready_after_reset", if8.s_ready, 1'b1);

        $display("[TB] basic 8N1 frame");
        add_word(9'h0A5, 3, PAR_NONE, 1'b0);
        apply_stimulus("a5_8n1");

        $display("[TB] parity and two stop bits");
        add_word(9'h0A5, 3, PAR_EVEN, 1'b0);
        apply_stimulus("a5_even");
        add_word(9'h0A5, 3, PAR_ODD, 1'b0);
        apply_stimulus("a5_odd");
        add_word(9'h0A5, 3, PAR_NONE, 1'b1);
        apply_stimulus("a5_stop2");

        $display("[TB] back-to-back frames");
        add_word(9'h000, 3, PAR_NONE, 1'b0);
        add_word(9'h0FF, 3, PAR_NONE, 1'b0);
        apply_stimulus("b2b");

        $display("[TB] five-bit instance, one clk per bit");
        sel = 1'b1;
        add_word(9'h015, 0, PAR_NONE, 1'b0);
        apply_stimulus("w5_div0");
        sel = 1'b0;

        $display("[TB] config change between frames");
        add_word(9'h0A5, 3, PAR_NONE, 1'b0);
        add_word(9'h05A, 7, PAR_EVEN, 1'b0);
        apply_stimulus("cfg_change");

        $display("[TB] asynchronous reset mid-frame");
        @(negedge clk);
        valid = 1'b1;
        data  = 9'h0A5;
        present_cfg('{d: 9'h0A5, div: 3, pm: PAR_NONE, s2: 1'b0});
        @(negedge clk);
        valid = 1'b0;
        scramble_cfg();
        repeat (17) @(negedge clk);
        check_output("pre_reset_bit3", tx8, 1'b0);
        #2 reset = 1'b1;
        #1;
        check_output("async_reset_tx", tx8, 1'b1);
        check_output("async_reset_busy", busy8, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_output("ready_after_midreset", if8.s_ready, 1'b1);
        add_word(9'h03C, 3, PAR_NONE, 1'b0);
        apply_stimulus("post_reset_3c");

        $display("[TB] randomized streams");
        for (int r = 0; r < 8; r++) begin
            int n;
            sel = 1'($urandom);
            n   = $urandom_range(1, 3);
            for (int k = 0; k < n; k++)
                add_word(9'($urandom), $urandom_range(0, 4), 2'($urandom), 1'($urandom));
            apply_stimulus($sformatf("rand%0d", r));
        end
        sel = 1'b0;

`ifdef UART_TX_BREAK_EN
        $display("[TB] line break");
        @(negedge clk);
        baud_div = 16'd3;
        brk      = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            scramble_cfg();
            check_output($sformatf("brk_low_tx[%0d]", i), tx8, 1'b0);
            check_output($sformatf("brk_low_busy[%0d]", i), busy8, 1'b1);
            check_output($sformatf("brk_low_ready[%0d]", i), if8.s_ready, 1'b0);
        end
        brk = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_output($sformatf("brk_high_tx[%0d]", i), tx8, 1'b1);
            check_output($sformatf("brk_high_busy[%0d]", i), busy8, 1'b1);
            check_output($sformatf("brk_high_ready[%0d]", i), if8.s_ready, 1'b0);
        end
        @(negedge clk);
        check_output("brk_end_ready", if8.s_ready, 1'b1);
        check_output("brk_end_busy", busy8, 1'b0);
        check_output("brk_end_tx", tx8, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
